// File: rtl/instr_cycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_ctrl_pkg
//  Description : Shared types and constants for the 4-bit CPU control path.
//                Holds the sequencer state enum, the 2-bit PHASE output
//                encoding and the instruction width.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int INST_W = 8;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_DECODE = 3'd2,
        PH_EXEC   = 3'd3,
        PH_WRITE  = 3'd4
    } phase_e;

    // Externally visible phase encoding; IDLE and FETCH share code 0.
    localparam logic [1:0] PHASE_IDLE   = 2'd0;
    localparam logic [1:0] PHASE_DECODE = 2'd1;
    localparam logic [1:0] PHASE_EXEC   = 2'd2;
    localparam logic [1:0] PHASE_WRITE  = 2'd3;

    function automatic logic [1:0] phase_code(input phase_e st);
        logic [1:0] code;
        code = PHASE_IDLE;
        case (st)
            PH_DECODE: code = PHASE_DECODE;
            PH_EXEC:   code = PHASE_EXEC;
            PH_WRITE:  code = PHASE_WRITE;
            default:   code = PHASE_IDLE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : instr_cycle_sequencer_if
//  Description : Switch inputs and datapath control outputs of the
//                instruction-cycle sequencer.
//                  sw_start  raw start switch
//                  sw_inst   raw instruction switches
//                  inst      latched instruction
//                  dec_en / alu_en / wri_en  one-cycle phase strobes
//                  busy      high FETCH..last WRITE cycle
//                  done      one-cycle pulse after last WRITE cycle
//                  phase     0=IDLE/FETCH 1=DECODE 2=EXEC 3=WRITE
//                master = switch/datapath side, slave = sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_cycle_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic              sw_start;
    logic [INST_W-1:0] sw_inst;
    logic [INST_W-1:0] inst;
    logic              dec_en;
    logic              alu_en;
    logic              wri_en;
    logic              busy;
    logic              done;
    logic [1:0]        phase;

    modport master (
        output sw_start, sw_inst,
        input  inst, dec_en, alu_en, wri_en, busy, done, phase
    );

    modport slave (
        input  sw_start, sw_inst,
        output inst, dec_en, alu_en, wri_en, busy, done, phase
    );

endinterface
`default_nettype wire

// File: rtl/instr_cycle_sequencer_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : Two-flop synchroniser followed by a stability counter for a
//                mechanical switch. The debounced level changes only after
//                DEB_CYCLES consecutive samples disagree with it. A one-cycle
//                press pulse accompanies each released->pressed flip.
//  Ports       : clk, rst (sync, active-high)
//                raw    asynchronous switch input
//                level  debounced level, 1 = pressed
//                press  one-cycle pulse on released->pressed flip
//  Parameters  : DEB_CYCLES  stable samples required for a level change
//                ACTIVE_LOW  1: raw = 0 means pressed
//  Revision    : 1.0  initial release
// ============================================================================
module sw_debounce #(
    parameter int DEB_CYCLES = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic raw,
    output logic      level,
    output logic      press
);

    localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Polarity is folded in before the synchroniser so every register works
    // in the "1 = pressed" domain; clearing them on reset means released.
    logic             w_raw_pressed;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;

    assign w_raw_pressed = raw ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= w_raw_pressed;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    // Only the released->pressed transition produces a pulse.
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/instr_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_cycle_sequencer
//  Description : Single-clock instruction-cycle controller. Debounces the
//                start switch, latches the instruction switches at FETCH and
//                issues one-cycle DECODE / EXEC / WRITE enables so that all
//                datapath registers run on clk.
//  Ports       : clk, rst (sync, active-high)
//                bus  instr_cycle_sequencer_if.slave
//                     (sw_start, sw_inst -> inst, dec_en, alu_en, wri_en,
//                      busy, done, phase)
//  Parameters  : DEB_CYCLES, PHASE_GAP (0..15), START_ACTIVE_LOW,
//                REPEAT_CYCLES
//  Macros      : AUTO_REPEAT_EN  enables synthetic presses every
//                REPEAT_CYCLES while the start switch stays held
//  Revision    : 1.0  initial release
// ============================================================================
module instr_cycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES       = 50000,
    parameter int PHASE_GAP        = 0,
    parameter int START_ACTIVE_LOW = 1,
    parameter int REPEAT_CYCLES    = 1000000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    instr_cycle_sequencer_if.slave  bus
);

    localparam logic [3:0] GAP_LAST = (PHASE_GAP > 15) ? 4'd15 : 4'(PHASE_GAP);

    logic              w_level;
    logic              w_press;
    logic              w_start;

    phase_e            r_state;
    logic [3:0]        r_gap_cnt;
    logic [3:0]        w_gap_next;
    logic              w_gap_done;
    logic [INST_W-1:0] r_inst;
    logic              r_dec_en;
    logic              r_alu_en;
    logic              r_wri_en;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_phase;

    sw_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .ACTIVE_LOW (START_ACTIVE_LOW != 0)
    ) u_start_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.sw_start),
        .level (w_level),
        .press (w_press)
    );

`ifdef AUTO_REPEAT_EN
    localparam int             REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             w_rep_fire;

    // The counter runs whenever the switch is held; it saturates at its
    // terminal value while an instruction is still in flight and fires once
    // the FSM is back in IDLE.
    assign w_rep_fire = w_level && (r_state == PH_IDLE) && (r_rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (rst || !w_level || w_press || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else if (r_rep_cnt != REP_LAST) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
        end
    end

    assign w_start = w_press | w_rep_fire;
`else
    logic [32:0] w_unused_cfg;

    assign w_unused_cfg = {w_level, 32'(REPEAT_CYCLES)};
    assign w_start      = w_press;
`endif

    // Per-phase stretch counter: saturates at 15, reloaded on phase entry.
    assign w_gap_next = (r_gap_cnt == 4'hF) ? r_gap_cnt : r_gap_cnt + 4'd1;
    assign w_gap_done = (r_gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= PH_IDLE;
            r_gap_cnt <= 4'd0;
            r_inst    <= '0;
            r_dec_en  <= 1'b0;
            r_alu_en  <= 1'b0;
            r_wri_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_phase   <= PHASE_IDLE;
        end else begin
            r_dec_en <= 1'b0;
            r_alu_en <= 1'b0;
            r_wri_en <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                PH_IDLE: begin
                    // A press in the DONE cycle lands here and is accepted.
                    if (w_start) begin
                        r_state <= PH_FETCH;
                        r_busy  <= 1'b1;
                        r_phase <= phase_code(PH_FETCH);
                    end
                end
                PH_FETCH: begin
                    r_inst    <= bus.sw_inst;
                    r_state   <= PH_DECODE;
                    r_phase   <= phase_code(PH_DECODE);
                    r_dec_en  <= 1'b1;
                    r_gap_cnt <= 4'd0;
                end
                PH_DECODE: begin
                    if (w_gap_done) begin
                        r_state   <= PH_EXEC;
                        r_phase   <= phase_code(PH_EXEC);
                        r_alu_en  <= 1'b1;
                        r_gap_cnt <= 4'd0;
                    end else begin
                        r_gap_cnt <= w_gap_next;
                    end
                end
                PH_EXEC: begin
                    if (w_gap_done) begin
                        r_state   <= PH_WRITE;
                        r_phase   <= phase_code(PH_WRITE);
                        r_wri_en  <= 1'b1;
                        r_gap_cnt <= 4'd0;
                    end else begin
                        r_gap_cnt <= w_gap_next;
                    end
                end
                PH_WRITE: begin
                    if (w_gap_done) begin
                        r_state   <= PH_IDLE;
                        r_phase   <= phase_code(PH_IDLE);
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_gap_cnt <= 4'd0;
                    end else begin
                        r_gap_cnt <= w_gap_next;
                    end
                end
                default: begin
                    r_state <= PH_IDLE;
                    r_phase <= PHASE_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst   = r_inst;
    assign bus.dec_en = r_dec_en;
    assign bus.alu_en = r_alu_en;
    assign bus.wri_en = r_wri_en;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.phase  = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_instr_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_cycle_sequencer
//  Description : Directed self-checking bench for instr_cycle_sequencer.
//                Instance A uses PHASE_GAP=0, instance B PHASE_GAP=3; both
//                DEB_CYCLES=4, active-low start, REPEAT_CYCLES=20.
//                Sample index k = value seen 1 time unit after the k-th
//                rising edge following the stimulus change; with a 4-sample
//                debouncer behind a 2-flop synchroniser FETCH is at k=7.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_cycle_sequencer;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    instr_cycle_sequencer_if ifa ();
    instr_cycle_sequencer_if ifb ();

    instr_cycle_sequencer #(
        .DEB_CYCLES(4), .PHASE_GAP(0), .START_ACTIVE_LOW(1), .REPEAT_CYCLES(20)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    instr_cycle_sequencer #(
        .DEB_CYCLES(4), .PHASE_GAP(3), .START_ACTIVE_LOW(1), .REPEAT_CYCLES(20)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    int checks = 0;
    int passed = 0;

    // Per-window activity record
    int cyc, n_busy, n_dec, n_alu, n_wri, n_done, n_bad;
    int t_fetch, t_dec, t_alu, t_wri, t_done;
    logic [1:0] ph_dec, ph_alu, ph_wri;

    task automatic clear_rec();
        cyc = 0; n_busy = 0; n_dec = 0; n_alu = 0; n_wri = 0; n_done = 0; n_bad = 0;
        t_fetch = -1; t_dec = -1; t_alu = -1; t_wri = -1; t_done = -1;
        ph_dec = 2'd0; ph_alu = 2'd0; ph_wri = 2'd0;
    endtask

    // Advance one clock and log what the selected instance did.
    task automatic tick(input bit sel);
        logic d, a, w, b, dn;
        logic [1:0] ph;
        @(posedge clk);
        #1;
        if (sel == 1'b0) begin
            d = ifa.dec_en; a = ifa.alu_en; w = ifa.wri_en; b = ifa.busy; dn = ifa.done; ph = ifa.phase;
        end else begin
            d = ifb.dec_en; a = ifb.alu_en; w = ifb.wri_en; b = ifb.busy; dn = ifb.done; ph = ifb.phase;
        end
        cyc++;
        if (b)  begin n_busy++; if (t_fetch < 0) t_fetch = cyc; end
        if (d)  begin n_dec++;  if (t_dec   < 0) t_dec   = cyc; ph_dec = ph; end
        if (a)  begin n_alu++;  if (t_alu   < 0) t_alu   = cyc; ph_alu = ph; end
        if (w)  begin n_wri++;  if (t_wri   < 0) t_wri   = cyc; ph_wri = ph; end
        if (dn) begin n_done++; if (t_done  < 0) t_done  = cyc; end
        if ((int'(d) + int'(a) + int'(w)) > 1) n_bad++;
        if ((d | a | w) && (ph == 2'd0)) n_bad++;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.sw_start = 1'b1; ifb.sw_start = 1'b1;
        ifa.sw_inst = 8'h00; ifb.sw_inst = 8'h00;
        settle(3);
        checks++; if (ifa.inst !== 8'h00) $display("FAIL reset_inst: got %h expected 00", ifa.inst); else passed++;
        checks++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ifa.busy); else passed++;
        checks++; if (ifa.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", ifa.done); else passed++;
        checks++; if (ifa.phase !== 2'd0) $display("FAIL reset_phase: got %0d expected 0", ifa.phase); else passed++;
        checks++; if ({ifa.dec_en, ifa.alu_en, ifa.wri_en} !== 3'b000) $display("FAIL reset_strobes: got %b expected 000", {ifa.dec_en, ifa.alu_en, ifa.wri_en}); else passed++;
        checks++; if ({ifb.busy, ifb.phase} !== 3'b000) $display("FAIL reset_b_busy_phase: got %b expected 000", {ifb.busy, ifb.phase}); else passed++;
        rst_a = 1'b0; rst_b = 1'b0;
        settle(8);
        checks++; if (ifa.busy !== 1'b0) $display("FAIL idle_after_reset_busy: got %b expected 0", ifa.busy); else passed++;
    endtask

    task automatic test_single_instr();
        clear_rec();
        ifa.sw_inst = 8'hA5;
        ifa.sw_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0);
            if (k == 10) ifa.sw_start = 1'b1;
        end
        checks++; if (t_fetch !== 7) $display("FAIL t1_fetch_cycle: got %0d expected 7", t_fetch); else passed++;
        checks++; if (t_dec !== 8) $display("FAIL t1_dec_cycle: got %0d expected 8", t_dec); else passed++;
        checks++; if (t_alu !== 9) $display("FAIL t1_alu_cycle: got %0d expected 9", t_alu); else passed++;
        checks++; if (t_wri !== 10) $display("FAIL t1_wri_cycle: got %0d expected 10", t_wri); else passed++;
        checks++; if (t_done !== 11) $display("FAIL t1_done_cycle: got %0d expected 11", t_done); else passed++;
        checks++; if ({n_dec, n_alu, n_wri} !== {32'd1, 32'd1, 32'd1}) $display("FAIL t1_strobe_counts: got %0d/%0d/%0d expected 1/1/1", n_dec, n_alu, n_wri); else passed++;
        checks++; if (n_done !== 1) $display("FAIL t1_done_count: got %0d expected 1", n_done); else passed++;
        checks++; if (n_busy !== 4) $display("FAIL t1_busy_cycles: got %0d expected 4", n_busy); else passed++;
        checks++; if (ifa.inst !== 8'hA5) $display("FAIL t1_inst: got %h expected a5", ifa.inst); else passed++;
        checks++; if ({ph_dec, ph_alu, ph_wri} !== 6'b01_10_11) $display("FAIL t1_phase_codes: got %0d/%0d/%0d expected 1/2/3", ph_dec, ph_alu, ph_wri); else passed++;
        checks++; if (n_bad !== 0) $display("FAIL t1_strobe_exclusive: got %0d bad cycles expected 0", n_bad); else passed++;
        settle(6);
    endtask

    task automatic test_glitch();
        clear_rec();
        ifa.sw_start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick(1'b0);
            if (k == 2) ifa.sw_start = 1'b1;
        end
        checks++; if (n_busy !== 0) $display("FAIL glitch_busy: got %0d busy cycles expected 0", n_busy); else passed++;
        checks++; if (n_done !== 0) $display("FAIL glitch_done: got %0d expected 0", n_done); else passed++;
    endtask

    task automatic test_busy_ignore();
        clear_rec();
        ifb.sw_inst = 8'h11;
        ifb.sw_start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            tick(1'b1);
            if (k == 7)  ifb.sw_start = 1'b1;
            if (k == 11) ifb.sw_start = 1'b0;   // second press lands at k=17, mid WRITE
            if (k == 30) ifb.sw_start = 1'b1;
        end
        checks++; if (t_dec !== 8) $display("FAIL gap_dec_cycle: got %0d expected 8", t_dec); else passed++;
        checks++; if (t_alu !== 12) $display("FAIL gap_alu_cycle: got %0d expected 12", t_alu); else passed++;
        checks++; if (t_wri !== 16) $display("FAIL gap_wri_cycle: got %0d expected 16", t_wri); else passed++;
        checks++; if (t_done !== 20) $display("FAIL gap_done_cycle: got %0d expected 20", t_done); else passed++;
        checks++; if (n_busy !== 13) $display("FAIL gap_busy_cycles: got %0d expected 13", n_busy); else passed++;
        checks++; if (n_done !== 1) $display("FAIL gap_done_count: got %0d expected 1", n_done); else passed++;
        checks++; if (n_dec !== 1) $display("FAIL gap_press_ignored: got %0d decodes expected 1", n_dec); else passed++;
        checks++; if (n_bad !== 0) $display("FAIL gap_strobe_exclusive: got %0d bad cycles expected 0", n_bad); else passed++;
        settle(6);
    endtask

    task automatic test_inst_hold();
        clear_rec();
        ifa.sw_inst = 8'h3C;
        ifa.sw_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0);
            if (k == 9) begin
                checks++; if (ifa.alu_en !== 1'b1) $display("FAIL hold_in_exec: got alu_en %b expected 1", ifa.alu_en); else passed++;
                checks++; if (ifa.inst !== 8'h3C) $display("FAIL hold_inst_exec: got %h expected 3c", ifa.inst); else passed++;
                ifa.sw_inst = 8'hFF;
            end
            if (k == 10) ifa.sw_start = 1'b1;
        end
        checks++; if (ifa.inst !== 8'h3C) $display("FAIL hold_inst_after: got %h expected 3c", ifa.inst); else passed++;
        settle(6);
        clear_rec();
        ifa.sw_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0);
            if (k == 10) ifa.sw_start = 1'b1;
        end
        checks++; if (ifa.inst !== 8'hFF) $display("FAIL hold_inst_next_fetch: got %h expected ff", ifa.inst); else passed++;
        checks++; if (t_fetch !== 7) $display("FAIL hold_second_fetch: got %0d expected 7", t_fetch); else passed++;
        settle(6);
    endtask

    task automatic test_reset_mid();
        clear_rec();
        ifa.sw_inst = 8'h5A;
        ifa.sw_start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0);
            if (k == 9) begin
                rst_a = 1'b1;
                ifa.sw_start = 1'b1;
            end
            if (k == 10) begin
                checks++; if (ifa.phase !== 2'd0) $display("FAIL rstmid_phase: got %0d expected 0", ifa.phase); else passed++;
                checks++; if (ifa.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", ifa.busy); else passed++;
                checks++; if (ifa.inst !== 8'h00) $display("FAIL rstmid_inst: got %h expected 00", ifa.inst); else passed++;
                checks++; if ({ifa.dec_en, ifa.alu_en, ifa.wri_en, ifa.done} !== 4'b0000) $display("FAIL rstmid_strobes: got %b expected 0000", {ifa.dec_en, ifa.alu_en, ifa.wri_en, ifa.done}); else passed++;
                rst_a = 1'b0;
            end
        end
        checks++; if (t_alu !== 9) $display("FAIL rstmid_reached_exec: got %0d expected 9", t_alu); else passed++;
        checks++; if (n_wri !== 0) $display("FAIL rstmid_no_write: got %0d expected 0", n_wri); else passed++;
        checks++; if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d expected 0", n_done); else passed++;
        settle(6);
    endtask

    task automatic test_hold_repeat();
        int exp_n;
`ifdef AUTO_REPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        clear_rec();
        ifa.sw_inst = 8'h77;
        ifa.sw_start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick(1'b0);
            if (k == 70) ifa.sw_start = 1'b1;
        end
        checks++; if (t_fetch !== 7) $display("FAIL repeat_first_fetch: got %0d expected 7", t_fetch); else passed++;
        checks++; if (n_done !== exp_n) $display("FAIL repeat_done_count: got %0d expected %0d", n_done, exp_n); else passed++;
        checks++; if (n_dec !== exp_n) $display("FAIL repeat_dec_count: got %0d expected %0d", n_dec, exp_n); else passed++;
        checks++; if (n_bad !== 0) $display("FAIL repeat_strobe_exclusive: got %0d bad cycles expected 0", n_bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_instr();
        test_glitch();
        test_busy_ignore();
        test_inst_hold();
        test_reset_mid();
        test_hold_repeat();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
